ex_mem_pipe_reg: RTL and testbench

- Pipeline register between the execute stage (64-bit ALU producing result, Z, C) and the memory stage.
- Captures the ALU result, flags and forwarded control bits each cycle, supporting stall (hold) and flush (bubble).
- Holds the architectural Z/C flag register.
- Resolves B.cond and CBZ so a taken branch and its target are presented registered to the fetch/memory stage.

---
 rtl/ex_mem_pipe_reg.sv | 167 ++++++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures ALU result, forwarded control and the
// resolved branch decision, and owns the architectural Z/C flag register.
module ex_mem_pipe_reg #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_set_flags,
  input  logic              ex_branch,
  input  logic              ex_cbz,
  input  logic [3:0]        ex_cond,
  input  logic [DATA_W-1:0] ex_target,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic              mem_branch_taken,
  output logic [DATA_W-1:0] mem_target,
  output logic              flag_z,
  output logic              flag_c,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] alu_res_reg, alu_res_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [REG_W-1:0]  rd_reg, rd_next;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic              reg_write_reg, reg_write_next;
  logic              taken_reg, taken_next;
  logic [DATA_W-1:0] target_reg, target_next;
  logic              flag_z_reg, flag_z_next;
  logic              flag_c_reg, flag_c_next;
  logic [CNT_W-1:0]  bubble_cnt_reg, bubble_cnt_next;

  logic cond_true;
  logic branch_taken;
  logic load_real;
  logic load_bubble;
  logic load_data;

  // Conditions read the flag register as it stood before this edge, so a
  // SUBS on edge N feeds a B.cond resolved on edge N+1.
  always_comb begin
    cond_true = 1'b0;
    case (ex_cond)
      4'b0000: cond_true = flag_z_reg;
      4'b0001: cond_true = ~flag_z_reg;
      4'b0010: cond_true = flag_c_reg;
      4'b0011: cond_true = ~flag_c_reg;
      4'b1000: cond_true = flag_c_reg & ~flag_z_reg;
      4'b1001: cond_true = ~flag_c_reg | flag_z_reg;
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign branch_taken = ex_valid & ((ex_branch & cond_true) | (ex_cbz & alu_z));
  assign load_data    = flush | ~stall;
  assign load_real    = ~flush & ~stall & ex_valid;
  assign load_bubble  = flush | (~stall & ~ex_valid);

  always_comb begin
    valid_next      = valid_reg;
    alu_res_next    = alu_res_reg;
    wdata_next      = wdata_reg;
    rd_next         = rd_reg;
    mem_read_next   = mem_read_reg;
    mem_write_next  = mem_write_reg;
    reg_write_next  = reg_write_reg;
    taken_next      = taken_reg;
    target_next     = target_reg;
    flag_z_next     = flag_z_reg;
    flag_c_next     = flag_c_reg;
    bubble_cnt_next = bubble_cnt_reg;

    // Data fields follow EX on any non-held edge, bubbles included.
    if (load_data) begin
      alu_res_next = alu_res;
      wdata_next   = ex_wdata;
      rd_next      = ex_rd;
      target_next  = ex_target;
    end

    if (load_real) begin
      valid_next     = 1'b1;
      mem_read_next  = ex_mem_read;
      mem_write_next = ex_mem_write;
      reg_write_next = ex_reg_write;
      taken_next     = branch_taken;
      if (ex_set_flags) begin
        flag_z_next = alu_z;
        flag_c_next = alu_c;
      end
    end else if (load_bubble) begin
      valid_next     = 1'b0;
      mem_read_next  = 1'b0;
      mem_write_next = 1'b0;
      reg_write_next = 1'b0;
      taken_next     = 1'b0;
      if (!(&bubble_cnt_reg)) begin
        bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      alu_res_reg    <= '0;
      wdata_reg      <= '0;
      rd_reg         <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      taken_reg      <= 1'b0;
      target_reg     <= '0;
      flag_z_reg     <= 1'b0;
      flag_c_reg     <= 1'b0;
      bubble_cnt_reg <= '0;
    end else begin
      valid_reg      <= valid_next;
      alu_res_reg    <= alu_res_next;
      wdata_reg      <= wdata_next;
      rd_reg         <= rd_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      reg_write_reg  <= reg_write_next;
      taken_reg      <= taken_next;
      target_reg     <= target_next;
      flag_z_reg     <= flag_z_next;
      flag_c_reg     <= flag_c_next;
      bubble_cnt_reg <= bubble_cnt_next;
    end
  end

  assign mem_valid        = valid_reg;
  assign mem_alu_res      = alu_res_reg;
  assign mem_wdata        = wdata_reg;
  assign mem_rd           = rd_reg;
  assign mem_mem_read     = mem_read_reg;
  assign mem_mem_write    = mem_write_reg;
  assign mem_reg_write    = reg_write_reg;
  assign mem_branch_taken = taken_reg;
  assign mem_target       = target_reg;
  assign flag_z           = flag_z_reg;
  assign flag_c           = flag_c_reg;
  assign bubble_cnt       = bubble_cnt_reg;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Testbench for ex_mem_pipe_reg: directed scenarios plus randomized traffic
// compared against a rule-level model of the pipeline register.
module tb_ex_mem_pipe_reg;

  localparam int DATA_W  = 64;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VW      = 3 * DATA_W + REG_W + 7 + CNT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, ex_valid;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c;
  logic [DATA_W-1:0] ex_wdata;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_mem_read, ex_mem_write, ex_reg_write, ex_set_flags;
  logic              ex_branch, ex_cbz;
  logic [3:0]        ex_cond;
  logic [DATA_W-1:0] ex_target;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_res, mem_wdata, mem_target;
  logic [REG_W-1:0]  mem_rd;
  logic              mem_mem_read, mem_mem_write, mem_reg_write, mem_branch_taken;
  logic              flag_z, flag_c;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  logic              m_valid, m_mr, m_mw, m_rw, m_taken, m_z, m_c;
  logic [DATA_W-1:0] m_res, m_wdata, m_target;
  logic [REG_W-1:0]  m_rd;
  int                m_cnt;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_res(alu_res), .alu_z(alu_z), .alu_c(alu_c), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_set_flags(ex_set_flags),
    .ex_branch(ex_branch), .ex_cbz(ex_cbz), .ex_cond(ex_cond),
    .ex_target(ex_target), .mem_valid(mem_valid), .mem_alu_res(mem_alu_res),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_reg_write(mem_reg_write),
    .mem_branch_taken(mem_branch_taken), .mem_target(mem_target),
    .flag_z(flag_z), .flag_c(flag_c), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] dut_vec();
    return {mem_valid, mem_alu_res, mem_wdata, mem_rd, mem_mem_read, mem_mem_write,
            mem_reg_write, mem_branch_taken, mem_target, flag_z, flag_c, bubble_cnt};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_res, m_wdata, m_rd, m_mr, m_mw, m_rw, m_taken, m_target,
            m_z, m_c, CNT_W'(m_cnt)};
  endfunction

  function automatic bit cond_holds(input logic [3:0] code, input bit z, input bit c);
    case (code)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd8:    return c && !z;
      4'd9:    return !c || z;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {m_valid, m_mr, m_mw, m_rw, m_taken, m_z, m_c} = '0;
    m_res = '0; m_wdata = '0; m_target = '0; m_rd = '0; m_cnt = 0;
  endtask

  // One clock edge of the pipeline register as described by its rules.
  task automatic model_edge();
    bit is_bubble, take;
    if (stall && !flush) return;
    m_res = alu_res; m_wdata = ex_wdata; m_rd = ex_rd; m_target = ex_target;
    is_bubble = flush || !ex_valid;
    if (is_bubble) begin
      m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_taken = 0;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else begin
      take = (ex_branch && cond_holds(ex_cond, m_z, m_c)) || (ex_cbz && alu_z);
      m_valid = 1; m_mr = ex_mem_read; m_mw = ex_mem_write; m_rw = ex_reg_write;
      m_taken = take;
      if (ex_set_flags) begin m_z = alu_z; m_c = alu_c; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; ex_valid = 0; alu_res = '0; alu_z = 0; alu_c = 0;
    ex_wdata = '0; ex_rd = '0; ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0;
    ex_set_flags = 0; ex_branch = 0; ex_cbz = 0; ex_cond = 4'h0; ex_target = '0;
  endtask

  task automatic rand_inputs();
    ex_valid = 1'($urandom); alu_res = {$urandom(), $urandom()};
    alu_z = 1'($urandom); alu_c = 1'($urandom); ex_wdata = {$urandom(), $urandom()};
    ex_rd = REG_W'($urandom); ex_mem_read = 1'($urandom); ex_mem_write = 1'($urandom);
    ex_reg_write = 1'($urandom); ex_set_flags = 1'($urandom);
    ex_branch = 1'($urandom); ex_cbz = 1'($urandom); ex_cond = 4'($urandom);
    ex_target = {$urandom(), $urandom()};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] zero_vec;
    zero_vec = '0;
    clear_inputs();
    rst_n = 0;
    model_reset();
    #3;
    n_checks++;
    if (dut_vec() !== zero_vec) $display("FAIL reset_state got=%h exp=%h", dut_vec(), zero_vec);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    ex_valid = 1; alu_res = 64'h15; ex_rd = 5'd3; ex_reg_write = 1;
    tick();
    $display("first load: res=%h rd=%0d rw=%b v=%b", mem_alu_res, mem_rd, mem_reg_write, mem_valid);
    n_checks++;
    if ({mem_alu_res, mem_rd, mem_reg_write, mem_valid} !== {64'h15, 5'd3, 1'b1, 1'b1})
      $display("FAIL first_load got=%h/%0d/%b/%b exp=15/3/1/1", mem_alu_res, mem_rd, mem_reg_write, mem_valid);
    else n_pass++;
    rand_inputs(); ex_valid = 1;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL pre_midreset got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    $display("mid-cycle reset asserted at %0t", $time);
    n_checks++;
    if (dut_vec() !== zero_vec) $display("FAIL midcycle_reset got=%h exp=%h", dut_vec(), zero_vec);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_branch_cond();
    logic [3:0] codes [4];
    bit         want  [4];
    codes = '{4'h0, 4'h1, 4'h8, 4'h2};
    want  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      ex_valid = 1; ex_set_flags = 1; alu_z = 1; alu_c = 1; alu_res = '0;
      tick();
      n_checks++;
      if ({flag_z, flag_c} !== 2'b11) $display("FAIL subs_flags got=%b%b exp=11", flag_z, flag_c);
      else n_pass++;
      clear_inputs();
      ex_valid = 1; ex_branch = 1; ex_cond = codes[i];
      tick();
      $display("b.cond %h: taken=%b", codes[i], mem_branch_taken);
      n_checks++;
      if (mem_branch_taken !== want[i])
        $display("FAIL bcond_%h got=%b exp=%b", codes[i], mem_branch_taken, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_cbz();
    logic [DATA_W-1:0] tgt;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      tgt = {$urandom(), $urandom()};
      ex_valid = 1; ex_cbz = 1; alu_z = (i == 0); alu_res = (i == 0) ? '0 : 64'h9;
      ex_target = tgt;
      tick();
      $display("cbz z=%0d: taken=%b target=%h", (i == 0), mem_branch_taken, mem_target);
      n_checks++;
      if ({mem_branch_taken, mem_target} !== {1'(i == 0), tgt})
        $display("FAIL cbz_%0d got=%b/%h exp=%b/%h", i, mem_branch_taken, mem_target, (i == 0), tgt);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    clear_inputs();
    rand_inputs(); ex_valid = 1;
    tick();
    snap = exp_vec();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); ex_valid = 1; ex_set_flags = 1; stall = 1;
      tick();
      $display("stall cycle %0d", i);
      n_checks++;
      if (dut_vec() !== snap) $display("FAIL stall_hold_%0d got=%h exp=%h", i, dut_vec(), snap);
      else n_pass++;
    end
    stall = 0;
    tick();
    n_checks++;
    if (mem_alu_res !== alu_res || dut_vec() !== exp_vec())
      $display("FAIL stall_release got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_flush_stall();
    bit z0, c0;
    do_reset();
    clear_inputs();
    ex_valid = 1; ex_set_flags = 1; alu_z = 1; alu_c = 0;
    tick();
    z0 = m_z; c0 = m_c;
    rand_inputs();
    ex_valid = 1; ex_mem_write = 1; stall = 1; flush = 1; ex_set_flags = 1;
    alu_z = ~z0; alu_c = ~c0;
    tick();
    $display("flush+stall: v=%b mw=%b cnt=%0d z=%b c=%b", mem_valid, mem_mem_write, bubble_cnt, flag_z, flag_c);
    n_checks++;
    if ({mem_valid, mem_mem_write, bubble_cnt, flag_z, flag_c, mem_alu_res} !==
        {1'b0, 1'b0, CNT_W'(1), z0, c0, alu_res})
      $display("FAIL flush_stall got=%b%b/%0d/%b%b/%h exp=00/1/%b%b/%h", mem_valid, mem_mem_write,
               bubble_cnt, flag_z, flag_c, mem_alu_res, z0, c0, alu_res);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    clear_inputs();
    for (int i = 1; i <= CNT_MAX + 4; i++) begin
      rand_inputs(); ex_valid = 0;
      tick();
      want = (i > CNT_MAX) ? CNT_MAX : i;
      $display("bubble %0d: cnt=%0d", i, bubble_cnt);
      n_checks++;
      if (bubble_cnt !== CNT_W'(want)) $display("FAIL bubble_sat_%0d got=%0d exp=%0d", i, bubble_cnt, want);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 40) == 0) do_reset();
      rand_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      tick();
      $display("rnd %0d: s=%b f=%b v=%b tk=%b cnt=%0d", i, stall, flush, mem_valid, mem_branch_taken, bubble_cnt);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL random_%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_branch_cond();
    test_cbz();
    test_stall();
    test_flush_stall();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
